// File: rtl/spi_txn_scheduler_pkg.sv
// Shared types for the SPI transaction scheduler: the SPI control word layout,
// the scheduler state encoding and the control-register write-through latency.
package spi_txn_scheduler_pkg;

    localparam int PC_AW        = 10;
    localparam int SCHED_WR_LAT = 2;

    typedef struct packed {
        logic [7:0]       clk_div;
        logic             cpol;
        logic             cpha;
        logic             all_1s;
        logic             all_0s;
        logic [PC_AW-1:0] n_tx_end;
        logic [PC_AW-1:0] n_rx_end;
        logic             send;
    } palabra_control;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_TX  = 3'd1,
        WR_CTRL  = 3'd2,
        WAIT_SPI = 3'd3,
        RD_RX    = 3'd4,
        DONE     = 3'd5
    } sched_state_t;

    function automatic palabra_control ctrl_with_send(input palabra_control c, input logic s);
        palabra_control r;
        r      = c;
        r.send = s;
        return r;
    endfunction

endpackage

// File: rtl/spi_txn_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       win,
    output logic [1:0] grant
);

    logic last;

    // Pointer starts at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last <= 1'b1;
        end else if (en) begin
            last <= win;
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Runs complete SPI transactions (TX load, control write, wait, RX drain) on the
// shared SPI master on behalf of two round-robin arbitrated requesters.
module spi_txn_scheduler
    import spi_txn_scheduler_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = PC_AW,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           req_i,
    input  palabra_control [1:0] ctrl_i,
    output logic [1:0]           ack_o,
    output logic [1:0]           err_o,
    input  logic [1:0][DW-1:0]   txd_i,
    input  logic [1:0]           txv_i,
    output logic [1:0]           txr_o,
    output logic [DW-1:0]        rxd_o,
    output logic [1:0]           rxv_o,
    input  logic [1:0]           rxr_i,
    output palabra_control       spi_ctrl_o,
    output logic                 spi_ctrl_we_o,
    input  logic                 spi_send_i,
    output logic [AW-1:0]        spi_addr_o,
    output logic [DW-1:0]        spi_tx_o,
    output logic                 spi_tx_we_o,
    input  logic [DW-1:0]        spi_rx_i,
    output logic                 busy_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t   state;
    logic           g;
    palabra_control ctrl_q;
    logic [AW-1:0]  idx;
    logic [TW-1:0]  tmo_cnt;
    logic           rd_vld;
    logic           rd_held;
    logic [DW-1:0]  rx_hold;

    logic [1:0]     arb_grant;
    logic [1:0]     g_oh;
    logic           arb_win;
    logic           arb_en;
    logic           skip_tx;
    logic           tx_hs;
    logic           rx_hs;
    logic           wait_done;
    logic           tmo_hit;
    logic [AW-1:0]  tx_last;
    logic [AW-1:0]  rx_last;

    assign arb_win = arb_grant[1];
    assign skip_tx = ctrl_i[arb_win].all_1s | ctrl_i[arb_win].all_0s;
    assign g_oh    = {g, ~g};
    assign tx_last = AW'(ctrl_q.n_tx_end);
    assign rx_last = AW'(ctrl_q.n_rx_end);

    assign tx_hs     = (state == LOAD_TX) && txv_i[g];
    assign rx_hs     = (state == RD_RX) && rd_vld && rxr_i[g];
    assign wait_done = (state == WAIT_SPI) && (tmo_cnt >= TW'(SCHED_WR_LAT)) && !spi_send_i;
    assign tmo_hit   = (state == WAIT_SPI) && !wait_done && (tmo_cnt == TW'(TIMEOUT - 1));

    // A timed-out requester also gives up its priority so it cannot starve the other.
    assign arb_en = (state == DONE) || tmo_hit;

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (req_i),
        .en    (arb_en),
        .win   (g),
        .grant (arb_grant)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            g       <= 1'b0;
            idx     <= '0;
            tmo_cnt <= '0;
            rd_vld  <= 1'b0;
            rd_held <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        g     <= arb_win;
                        idx   <= '0;
                        state <= skip_tx ? WR_CTRL : LOAD_TX;
                    end
                end
                LOAD_TX: begin
                    // Compare before increment so a full 2^AW-word load ends cleanly.
                    if (tx_hs) begin
                        if (idx == tx_last) begin
                            idx   <= '0;
                            state <= WR_CTRL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WR_CTRL: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_SPI;
                end
                WAIT_SPI: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (wait_done) begin
                        idx     <= '0;
                        rd_vld  <= 1'b0;
                        rd_held <= 1'b0;
                        state   <= RD_RX;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                RD_RX: begin
                    // Address phase first; the bank answers one cycle later.
                    if (!rd_vld) begin
                        rd_vld  <= 1'b1;
                        rd_held <= 1'b0;
                    end else begin
                        rd_held <= 1'b1;
                        if (rx_hs) begin
                            rd_vld <= 1'b0;
                            if (idx == rx_last) begin
                                state <= DONE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state == IDLE) && (|req_i)) begin
            ctrl_q <= ctrl_i[arb_win];
        end
        if ((state == RD_RX) && rd_vld && !rd_held) begin
            rx_hold <= spi_rx_i;
        end
    end

    always_comb begin
        ack_o         = '0;
        err_o         = '0;
        txr_o         = '0;
        rxd_o         = '0;
        rxv_o         = '0;
        spi_ctrl_o    = '0;
        spi_ctrl_we_o = 1'b0;
        spi_addr_o    = '0;
        spi_tx_o      = '0;
        spi_tx_we_o   = 1'b0;
        busy_o        = (state != IDLE);

        case (state)
            LOAD_TX: begin
                txr_o      = g_oh;
                spi_addr_o = idx;
                if (tx_hs) begin
                    spi_tx_we_o = 1'b1;
                    spi_tx_o    = txd_i[g];
                end
            end
            WR_CTRL: begin
                spi_ctrl_we_o = 1'b1;
                spi_ctrl_o    = ctrl_with_send(ctrl_q, 1'b1);
            end
            WAIT_SPI: begin
                if (tmo_hit) begin
                    spi_ctrl_we_o = 1'b1;
                    spi_ctrl_o    = ctrl_with_send(ctrl_q, 1'b0);
                    ack_o         = g_oh;
                    err_o         = g_oh;
                end
            end
            RD_RX: begin
                spi_addr_o = idx;
                // Hold the first-cycle bank data so the beat stays stable while stalled.
                if (rd_vld) begin
                    rxv_o = g_oh;
                    rxd_o = rd_held ? rx_hold : spi_rx_i;
                end
            end
            DONE: begin
                ack_o = g_oh;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a small SPI/register-bank model.
module tb_spi_txn_scheduler;
    import spi_txn_scheduler_pkg::*;

    localparam int DW      = 32;
    localparam int AW      = 10;
    localparam int TMO     = 100;
    localparam int SPI_LAT = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic [1:0]           req_i;
    palabra_control [1:0] ctrl_i;
    logic [1:0]           ack_o;
    logic [1:0]           err_o;
    logic [1:0][DW-1:0]   txd_i;
    logic [1:0]           txv_i;
    logic [1:0]           txr_o;
    logic [DW-1:0]        rxd_o;
    logic [1:0]           rxv_o;
    logic [1:0]           rxr_i;
    palabra_control       spi_ctrl_o;
    logic                 spi_ctrl_we_o;
    logic                 spi_send_i;
    logic [AW-1:0]        spi_addr_o;
    logic [DW-1:0]        spi_tx_o;
    logic                 spi_tx_we_o;
    logic [DW-1:0]        spi_rx_i;
    logic                 busy_o;

    always #5 clk_i = ~clk_i;

    spi_txn_scheduler #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .ctrl_i        (ctrl_i),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .txd_i         (txd_i),
        .txv_i         (txv_i),
        .txr_o         (txr_o),
        .rxd_o         (rxd_o),
        .rxv_o         (rxv_o),
        .rxr_i         (rxr_i),
        .spi_ctrl_o    (spi_ctrl_o),
        .spi_ctrl_we_o (spi_ctrl_we_o),
        .spi_send_i    (spi_send_i),
        .spi_addr_o    (spi_addr_o),
        .spi_tx_o      (spi_tx_o),
        .spi_tx_we_o   (spi_tx_we_o),
        .spi_rx_i      (spi_rx_i),
        .busy_o        (busy_o)
    );

    // SPI master model: send clears SPI_LAT cycles after a send=1 write unless held.
    logic hold_send = 1'b0;
    int   spi_cnt;
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            spi_send_i <= 1'b0;
            spi_cnt    <= 0;
        end else if (spi_ctrl_we_o) begin
            spi_send_i <= spi_ctrl_o.send;
            spi_cnt    <= SPI_LAT;
        end else if (spi_send_i && !hold_send) begin
            if (spi_cnt == 0) spi_send_i <= 1'b0;
            else spi_cnt <= spi_cnt - 1;
        end
    end

    always @(posedge clk_i) spi_rx_i <= 32'hB000_0000 | DW'(spi_addr_o);

    typedef struct {
        int             r;
        int             tx;
        int             rx;
        int             cw1;
        int             cw0;
        bit             err;
        int             dly;
        int             ack_dly;
        palabra_control c1;
        palabra_control c0;
    } rec_t;

    typedef struct {
        int       rounds0;
        int       rounds1;
        int       ntx;
        int       nrx;
        bit       a1;
        bit       a0;
        logic [2:0] order;
        int       exp_tx;
        int       exp_rx;
        int       exp_dly;
    } vec_t;

    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    int             req_left [2];
    int             taken    [2];
    int             cur_tx, cur_cw1, cur_cw0, rx_idx, stall_left;
    int             busy_cyc, cw1_cyc;
    bit             prev_busy, prev_stall, saw_addr3;
    logic [DW-1:0]  prev_rxd;
    logic [AW-1:0]  prev_addr;
    logic [1:0]     prev_rxv;
    palabra_control good [2];
    palabra_control junk;
    palabra_control cw1_val, cw0_val;
    rec_t           done_q [$];
    vec_t           vecs   [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] txbase(input int k);
        return 32'h0000_00A0 + DW'(k) * 32'h100;
    endfunction

    function automatic palabra_control mk(input int ntx, input int nrx, input bit a1, input bit a0);
        palabra_control c;
        c          = '0;
        c.clk_div  = 8'h12;
        c.cpha     = 1'b1;
        c.all_1s   = a1;
        c.all_0s   = a0;
        c.n_tx_end = AW'(ntx);
        c.n_rx_end = AW'(nrx);
        return c;
    endfunction

    function automatic bit outs_zero();
        return (ack_o == 2'b00) && (err_o == 2'b00) && (txr_o == 2'b00) && (rxd_o == '0) &&
               (rxv_o == 2'b00) && (spi_ctrl_o == '0) && !spi_ctrl_we_o && (spi_addr_o == '0) &&
               (spi_tx_o == '0) && !spi_tx_we_o && !busy_o;
    endfunction

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            req_i[k] = (req_left[k] > 0);
            txv_i[k] = 1'b1;
            txd_i[k] = txbase(k) + DW'(taken[k]);
            ctrl_i[k] = busy_o ? junk : good[k];
            rxr_i[k] = !((stall_left > 0) && (rx_idx == 2));
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            req_left[k] = 0;
            taken[k]    = 0;
        end
        cur_tx = 0; cur_cw1 = 0; cur_cw0 = 0; rx_idx = 0; stall_left = 0;
        prev_busy = 0; prev_stall = 0; saw_addr3 = 0;
        busy_cyc = 0; cw1_cyc = 0;
        done_q.delete();
    endtask

    // Sample on the falling edge, drive just after the rising edge.
    task automatic tick();
        int r;
        rec_t rc;
        @(negedge clk_i);
        cyc++;
        if (busy_o && !prev_busy) busy_cyc = cyc;
        prev_busy = busy_o;
        if (ack_o == 2'b11) begin
            total++;
            bad++;
            $display("FAIL ack_overlap: ack_o=%b required one-hot", ack_o);
        end
        if (err_o != 2'b00) chk("err_with_ack", 64'(ack_o), 64'(err_o));
        if (spi_tx_we_o) begin
            r = txr_o[1] ? 1 : 0;
            chk("tx_addr", 64'(spi_addr_o), 64'(cur_tx));
            chk("tx_data", 64'(spi_tx_o), 64'(txbase(r) + DW'(cur_tx)));
            if (spi_addr_o == AW'(3)) saw_addr3 = 1;
            cur_tx++;
        end
        if (spi_ctrl_we_o) begin
            if (spi_ctrl_o.send) begin
                cur_cw1++;
                cw1_val = spi_ctrl_o;
                cw1_cyc = cyc;
            end else begin
                cur_cw0++;
                cw0_val = spi_ctrl_o;
            end
        end
        if (prev_stall) chk("rx_hold_vld", 64'(rxv_o), 64'(prev_rxv));
        if (rxv_o != 2'b00) begin
            r = rxv_o[1] ? 1 : 0;
            if (prev_stall) begin
                chk("rx_hold_data", 64'(rxd_o), 64'(prev_rxd));
                chk("rx_hold_addr", 64'(spi_addr_o), 64'(prev_addr));
            end
            if (rxr_i[r]) begin
                chk("rx_data", 64'(rxd_o), 64'(32'hB000_0000 | DW'(rx_idx)));
                rx_idx++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                prev_rxd   = rxd_o;
                prev_addr  = spi_addr_o;
                prev_rxv   = rxv_o;
                if (stall_left > 0) stall_left--;
            end
        end else begin
            prev_stall = 0;
        end
        for (int k = 0; k < 2; k++) begin
            if (txv_i[k] && txr_o[k]) taken[k]++;
            if (ack_o[k]) begin
                rc.r = k; rc.tx = cur_tx; rc.rx = rx_idx; rc.cw1 = cur_cw1; rc.cw0 = cur_cw0;
                rc.err = err_o[k]; rc.dly = cw1_cyc - busy_cyc; rc.ack_dly = cyc - cw1_cyc;
                rc.c1 = cw1_val; rc.c0 = cw0_val;
                done_q.push_back(rc);
                cur_tx = 0; cur_cw1 = 0; cur_cw0 = 0; rx_idx = 0; taken[k] = 0;
                if (req_left[k] > 0) req_left[k]--;
            end
        end
        @(posedge clk_i);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        clear_mon();
        drive();
        #1;
        chk("reset_outs", 64'(outs_zero()), 64'd1);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    task automatic run_wait(input int n, input string nm);
        int c;
        c = 0;
        while (!((done_q.size() >= n) && !busy_o && (req_i == 2'b00)) && (c < 3000)) begin
            tick();
            c++;
        end
        chk({nm, "_count"}, 64'(done_q.size()), 64'(n));
        chk({nm, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int   n;
        rec_t rc;
        string nm;

        junk          = '1;
        junk.all_1s   = 1'b0;
        junk.all_0s   = 1'b0;
        good[0]       = '0;
        good[1]       = '0;
        req_i         = '0;
        txv_i         = '0;
        txd_i         = '0;
        rxr_i         = '0;
        ctrl_i        = '0;

        vecs[0] = '{1, 0, 5, 3, 1'b0, 1'b0, 3'b000, 6, 4, 6};
        vecs[1] = '{2, 1, 1, 1, 1'b0, 1'b0, 3'b010, 2, 2, 2};
        vecs[2] = '{1, 0, 7, 2, 1'b1, 1'b0, 3'b000, 0, 3, 0};
        vecs[3] = '{0, 1, 3, 0, 1'b0, 1'b1, 3'b001, 0, 1, 0};
        vecs[4] = '{0, 1, 0, 0, 1'b0, 1'b0, 3'b001, 1, 1, 1};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            good[0]     = mk(vecs[v].ntx, vecs[v].nrx, vecs[v].a1, vecs[v].a0);
            good[1]     = good[0];
            req_left[0] = vecs[v].rounds0;
            req_left[1] = vecs[v].rounds1;
            drive();
            n  = vecs[v].rounds0 + vecs[v].rounds1;
            nm = $sformatf("v%0d", v);
            run_wait(n, nm);
            for (int k = 0; k < n && k < done_q.size(); k++) begin
                rc = done_q[k];
                nm = $sformatf("v%0d_t%0d", v, k);
                chk({nm, "_grant"}, 64'(rc.r), 64'(vecs[v].order[k]));
                chk({nm, "_txn"}, 64'(rc.tx), 64'(vecs[v].exp_tx));
                chk({nm, "_rxn"}, 64'(rc.rx), 64'(vecs[v].exp_rx));
                chk({nm, "_cw1"}, 64'(rc.cw1), 64'd1);
                chk({nm, "_cw0"}, 64'(rc.cw0), 64'd0);
                chk({nm, "_cval"}, 64'(rc.c1), 64'(ctrl_with_send(good[rc.r], 1'b1)));
                chk({nm, "_dly"}, 64'(rc.dly), 64'(vecs[v].exp_dly));
                chk({nm, "_err"}, 64'(rc.err), 64'd0);
            end
        end

        // RX backpressure: requester 1 stalls word 2 for 10 cycles.
        do_reset();
        good[1]     = mk(1, 4, 1'b0, 1'b0);
        req_left[1] = 1;
        stall_left  = 10;
        drive();
        run_wait(1, "bp");
        if (done_q.size() > 0) begin
            rc = done_q[0];
            chk("bp_grant", 64'(rc.r), 64'd1);
            chk("bp_txn", 64'(rc.tx), 64'd2);
            chk("bp_rxn", 64'(rc.rx), 64'd5);
        end
        chk("bp_stalled", 64'(stall_left), 64'd0);

        // SPI never clears send: timeout path.
        do_reset();
        hold_send   = 1'b1;
        good[0]     = mk(0, 0, 1'b0, 1'b0);
        req_left[0] = 1;
        drive();
        run_wait(1, "tmo");
        if (done_q.size() > 0) begin
            rc = done_q[0];
            chk("tmo_err", 64'(rc.err), 64'd1);
            chk("tmo_rxn", 64'(rc.rx), 64'd0);
            chk("tmo_cw0", 64'(rc.cw0), 64'd1);
            chk("tmo_c0val", 64'(rc.c0), 64'(ctrl_with_send(good[0], 1'b0)));
            chk("tmo_latency", 64'(rc.ack_dly), 64'(TMO));
        end
        hold_send = 1'b0;

        // Reset during TX load, then a clean restart from address 0.
        do_reset();
        good[0]     = mk(7, 1, 1'b0, 1'b0);
        req_left[0] = 1;
        drive();
        n = 0;
        while (!saw_addr3 && n < 200) begin
            tick();
            n++;
        end
        chk("rst_reach_word3", 64'(saw_addr3), 64'd1);
        rst_i = 1'b0;
        #1;
        chk("midrst_outs", 64'(outs_zero()), 64'd1);
        clear_mon();
        drive();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        req_left[0] = 1;
        drive();
        run_wait(1, "rst");
        if (done_q.size() > 0) begin
            rc = done_q[0];
            chk("rst_txn", 64'(rc.tx), 64'd8);
            chk("rst_rxn", 64'(rc.rx), 64'd2);
            chk("rst_dly", 64'(rc.dly), 64'd8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
Sequences complete SPI transactions on the existing SPI master (module_fsm_spi plus its TX/RX register banks), shared between two requesters.
- Arbitrates round-robin between the requesters.
- Streams the winner's TX words into the TX bank, then writes the palabra_control word with send=1.
- Waits for the SPI FSM to clear send, then streams the RX words back to the same requester.
- Sits between the host-side clients and the SPI register interface; the clients never touch the SPI control register directly.

Parameters:
DW, 32, width of TX/RX data words
AW, 10, address width of TX/RX banks (matches n_tx_end/n_rx_end width)
TIMEOUT, 65535, clk_i cycles allowed in WAIT_SPI before abort

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-low reset
req_i  in  [1:0]  transaction request per requester, held until ack_o
ctrl_i  in  [1:0] x palabra_control  requested control word (send field ignored)
ack_o  out  [1:0]  one-cycle pulse, transaction finished for that requester
err_o  out  [1:0]  one-cycle pulse coincident with ack_o on timeout
txd_i  in  [1:0] x DW  TX word stream per requester
txv_i  in  [1:0]  TX word valid
txr_o  out  [1:0]  TX word ready
rxd_o  out  DW  RX word stream (shared)
rxv_o  out  [1:0]  RX word valid, one-hot to the granted requester
rxr_i  in  [1:0]  RX word ready
spi_ctrl_o  out  palabra_control  control word to SPI control register
spi_ctrl_we_o  out  1  control register write enable
spi_send_i  in  1  send bit read back from SPI control register
spi_addr_o  out  AW  TX/RX bank address
spi_tx_o  out  DW  TX bank write data
spi_tx_we_o  out  1  TX bank write enable
spi_rx_i  in  DW  RX bank read data, valid 1 cycle after spi_addr_o
busy_o  out  1  high from grant until ack

Behaviour:
- Reset (async, rst_i=0): state IDLE, last-grant pointer=1 (requester 0 wins first tie). All outputs 0, spi_ctrl_o='0.
- IDLE: if any req_i, register grant g and move to LOAD_TX next cycle.
  - Round-robin arbitration: the requester other than last grant wins a tie.
  - Latch ctrl_i[g] into a local copy.
- LOAD_TX:
  - If all_1s or all_0s is set in the latched word, skip straight to WR_CTRL; no TX words are taken.
  - Otherwise txr_o[g]=1. Each txv&txr cycle writes spi_tx_o=txd_i[g] at spi_addr_o=idx with spi_tx_we_o=1, then idx++.
  - Words 0..n_tx_end inclusive (n_tx_end+1 words). After the last word, go to WR_CTRL.
- WR_CTRL: one cycle, spi_ctrl_we_o=1, spi_ctrl_o = latched word with send=1.
- WAIT_SPI:
  - Wait at least 2 cycles for register write-through, then wait for spi_send_i=0, then go to RD_RX.
  - Timeout counter expiring at TIMEOUT: write the control word with send=0, pulse err_o[g] and ack_o[g], go to IDLE.
- RD_RX: for idx = 0..n_rx_end (read from the latched word):
  - Drive spi_addr_o=idx.
  - Next cycle, present rxd_o=spi_rx_i with rxv_o[g]=1.
  - Hold rxd_o and rxv_o stable until rxr_i[g]; then idx++.
  - After the last accepted word, go to DONE.
- DONE: pulse ack_o[g] for 1 cycle, update the last-grant pointer, return to IDLE. A new grant is possible on the following cycle.
- busy_o=1 in all states except IDLE.
- Arithmetic: idx is AW bits; n_tx_end=2^AW-1 completes without wrap-around (compare before increment).
- req_i dropping mid-transaction is ignored; the transaction always completes.
- A reset mid-operation aborts immediately. spi_send_i left high by the SPI block is not cleared by this block.
- ctrl_i changes after grant have no effect.

Decomposition:
- spi_pkg: reuse palabra_control; add the state enum sched_state_t (IDLE, LOAD_TX, WR_CTRL, WAIT_SPI, RD_RX, DONE) and the constant SCHED_WR_LAT=2.
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs req[1:0], last pointer, enable; output one-hot grant. Combinational plus the pointer register.

Test Plan:
- Single request 0, n_tx_end=5, n_rx_end=3, data 0xA0..0xA5 -> six TX writes at addr 0..5; one ctrl write with send=1; after the SPI model clears send, four rxv_o[0] beats of bank data; ack_o[0] pulses once.
- req_i=2'b11 simultaneous, three back-to-back rounds -> grant order 0,1,0; ack_o never overlaps.
- all_1s=1, n_tx_end=7 -> txr_o stays 0 and spi_tx_we_o never asserts; ctrl write occurs on the cycle after grant.
- Backpressure: rxr_i[1] low for 10 cycles on word 2 -> rxd_o and rxv_o stable across the stall; no address skip.
- SPI model holds send high, TIMEOUT=100 -> err_o and ack_o pulse together near cycle 100; ctrl write with send=0; scheduler returns to IDLE.
- rst_i low during LOAD_TX at word 3 -> all outputs 0 immediately; after release, a new request restarts at addr 0.
